// File: rtl/ether_tx_arbiter.sv
// ether_tx_arbiter: two-port arbiter that feeds one payload word plus its
// ethertype to a frame transmitter. It then holds the transmitter's inputs
// until the frame and inter-packet gap have finished.
// Build option: define ETHER_TX_ARB_FIXED_PRIO_EN to make port 0 win when
// both ports are valid. Without it, arbitration is round-robin.
module ether_tx_arbiter #(
    parameter int          FRAME_CYCLES = 345,
    parameter logic [15:0] ETHERTYPE0   = 16'h88B5,
    parameter logic [15:0] ETHERTYPE1   = 16'h88B6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        mac_start,
    output logic [15:0] mac_data,
    output logic [15:0] mac_ethertype,
    output logic        busy
);

    localparam int CW = $clog2(FRAME_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(FRAME_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic          last_grant_q, last_grant_d;
    logic [15:0]   mac_data_q, mac_data_d;
    logic [15:0]   mac_ethertype_q, mac_ethertype_d;

    logic grant_vld;
    logic grant_sel;

    // Pick the port to serve; only meaningful while idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
`ifdef ETHER_TX_ARB_FIXED_PRIO_EN
                grant_sel = 1'b0;
`else
                grant_sel = ~last_grant_q;
`endif
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_sel = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    // Ready goes to the granted port only, in the same cycle it is valid.
    always_comb begin
        req0_ready = grant_vld & ~grant_sel;
        req1_ready = grant_vld &  grant_sel;
    end

    // Next-state logic. A transfer latches the word, a one-cycle start
    // follows, and the counter then spans the rest of the frame.
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        last_grant_d    = last_grant_q;
        mac_data_d      = mac_data_q;
        mac_ethertype_d = mac_ethertype_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    mac_data_d      = grant_sel ? req1_data : req0_data;
                    mac_ethertype_d = grant_sel ? ETHERTYPE1 : ETHERTYPE0;
                    last_grant_d    = grant_sel;
                    state_d         = ST_START;
                end
            end
            ST_START: begin
                counter_d = CNT_RELOAD;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (counter_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    counter_d = counter_q - CNT_ONE;
                end
            end
            default: begin
                // An illegal encoding waits out a full frame before granting again.
                state_d   = ST_HOLD;
                counter_d = CNT_RELOAD;
            end
        endcase
    end

    // State registers. Reset lands in HOLD with a full count so that any frame
    // the transmitter is still sending finishes before the next grant.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q         <= ST_HOLD;
            counter_q       <= CNT_RELOAD;
            last_grant_q    <= 1'b1;
            mac_data_q      <= '0;
            mac_ethertype_q <= '0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            last_grant_q    <= last_grant_d;
            mac_data_q      <= mac_data_d;
            mac_ethertype_q <= mac_ethertype_d;
        end
    end

    // Outputs decode directly from the registers.
    always_comb begin
        mac_start     = (state_q == ST_START);
        busy          = (state_q != ST_IDLE);
        mac_data      = mac_data_q;
        mac_ethertype = mac_ethertype_q;
    end

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Testbench for ether_tx_arbiter. A timeline reference model tracks the cycle
// at which the arbiter becomes idle again, the cycle of the expected start
// pulse, and the held word. Every cycle, the DUT outputs are compared with
// that model. Directed scenarios are followed by a randomized run.
module tb_ether_tx_arbiter;

    localparam int FC = 345;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        mac_start, busy;
    logic [15:0] mac_data, mac_ethertype;

    ether_tx_arbiter #(
        .FRAME_CYCLES(FC),
        .ETHERTYPE0  (16'h88B5),
        .ETHERTYPE1  (16'h88B6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .mac_start    (mac_start),
        .mac_data     (mac_data),
        .mac_ethertype(mac_ethertype),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model state.
    longint      cyc       = 0;
    bit          mdl_known = 1'b0;
    longint      free_cyc  = 0;
    longint      start_cyc = -1;
    longint      rst_rel0  = 0;
    bit          mdl_last  = 1'b1;
    logic [15:0] mdl_data  = '0;
    logic [15:0] mdl_eth   = '0;

    // Observed events.
    longint obs_start_q[$];
    longint obs_grant_cyc[$];
    int     obs_grant_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle. Outputs are compared mid-cycle, and the model
    // advances using the inputs that the clock edge will sample.
    task automatic tick();
        logic [35:0] exp_v, act_v;
        logic        idle, e_r0, e_r1;
        int          g;
        @(negedge clk);
        idle = mdl_known && (cyc >= free_cyc);
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (idle) begin
            if (req0_valid && req1_valid) begin
`ifdef ETHER_TX_ARB_FIXED_PRIO_EN
                e_r0 = 1'b1;
`else
                if (mdl_last) e_r0 = 1'b1;
                else          e_r1 = 1'b1;
`endif
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
        end
        if (mdl_known) begin
            exp_v = {!idle, (cyc == start_cyc), e_r1, e_r0, mdl_data, mdl_eth};
            act_v = {busy, mac_start, req1_ready, req0_ready, mac_data, mac_ethertype};
            check($sformatf("cycle%0d {busy,start,rdy1,rdy0,data,eth}", cyc), 64'(act_v), 64'(exp_v));
        end
        if (req0_ready && req0_valid) begin obs_grant_q.push_back(0); obs_grant_cyc.push_back(cyc); end
        if (req1_ready && req1_valid) begin obs_grant_q.push_back(1); obs_grant_cyc.push_back(cyc); end
        if (mac_start) obs_start_q.push_back(cyc);
        if (!rst_n) begin
            mdl_known = 1'b1;
            free_cyc  = cyc + FC;
            start_cyc = -1;
            rst_rel0  = cyc + 1;
            mdl_last  = 1'b1;
            mdl_data  = '0;
            mdl_eth   = '0;
        end else if (idle && (e_r0 || e_r1)) begin
            g         = e_r1 ? 1 : 0;
            mdl_last  = e_r1;
            mdl_data  = e_r1 ? req1_data : req0_data;
            mdl_eth   = e_r1 ? 16'h88B6 : 16'h88B5;
            start_cyc = cyc + 1;
            free_cyc  = cyc + FC + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_obs();
        obs_start_q.delete();
        obs_grant_cyc.delete();
        obs_grant_q.delete();
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (obs_start_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (obs_start_q.size() < n) check({tag, "_timeout"}, 64'(obs_start_q.size()), 64'(n));
    endtask

    initial begin
        int          n_starts;
        int          exp_seq [4];
        logic [15:0] exp_hold_data;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 16'hBEEF;
        req1_valid = 1'b0; req1_data = 16'h0000;

        // Reset release with port 0 waiting: the first grant comes FC-1 cycles in.
        repeat (3) tick();
        rst_n = 1'b1;
        clear_obs();
        wait_starts(1, 1000, "first_start");
        if (obs_grant_cyc.size() > 0 && obs_start_q.size() > 0) begin
            check("first_ready_delay", 64'(obs_grant_cyc[0] - rst_rel0), 64'(FC - 1));
            check("first_start_after_ready", 64'(obs_start_q[0] - obs_grant_cyc[0]), 64'd1);
            check("first_grant_port", 64'(obs_grant_q[0]), 64'd0);
        end
        check("first_mac_data", 64'(mac_data), 64'h BEEF);
        check("first_mac_eth", 64'(mac_ethertype), 64'h88B5);
        req0_valid = 1'b0;

        // Both ports valid continuously, starting from reset (last_grant = 1).
        req0_valid = 1'b1; req0_data = 16'h0001;
        req1_valid = 1'b1; req1_data = 16'h0002;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_obs();
        wait_starts(4, 2500, "rr_starts");
`ifdef ETHER_TX_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
        exp_hold_data = 16'h0001;
`else
        exp_seq = '{0, 1, 0, 1};
        exp_hold_data = 16'h0002;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < obs_grant_q.size()) check($sformatf("grant_seq%0d", i), 64'(obs_grant_q[i]), 64'(exp_seq[i]));
        end
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < obs_start_q.size())
                check($sformatf("start_spacing%0d", i), 64'(obs_start_q[i+1] - obs_start_q[i]), 64'(FC + 1));
        end

        // Port 1 pulsed only while the transmitter is held: nothing is consumed.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_starts = obs_start_q.size();
        repeat (20) tick();
        req1_valid = 1'b1; req1_data = 16'hDEAD;
        repeat (30) tick();
        req1_valid = 1'b0;
        repeat (400) tick();
        check("hold_pulse_starts", 64'(obs_start_q.size()), 64'(n_starts));
        check("hold_pulse_grants", 64'(obs_grant_q.size()), 64'd4);
        check("hold_pulse_data", 64'(mac_data), 64'(exp_hold_data));

        // A one-cycle reset 100 cycles into HOLD restarts the full wait.
        clear_obs();
        req0_valid = 1'b1; req0_data = 16'($urandom);
        wait_starts(1, 400, "mid_frame_start");
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_obs();
        wait_starts(1, 600, "post_reset_start");
        if (obs_start_q.size() > 0)
            check("post_reset_start_delay", 64'(obs_start_q[0] - rst_rel0), 64'(FC));
        check("post_reset_grants", 64'(obs_grant_q.size()), 64'd1);

        // Randomized traffic with an occasional reset; checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = 16'($urandom);
            req1_data  = 16'($urandom);
            rst_n      = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ether_tx_arbiter.md
ETHER_TX_ARBITER -- requirements
Module: ether_tx_arbiter

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 345, meaning cycles from a mac_start pulse until the transmitter re-enters idle (344 frame/IPG dibits + 1 idle cycle).
REQ-002 SHALL have parameter ETHERTYPE0, default 16'h88B5, meaning ethertype sent for port 0 frames.
REQ-003 SHALL have parameter ETHERTYPE1, default 16'h88B6, meaning ethertype sent for port 1 frames.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req0_valid  input  1  port 0 has a payload word.
REQ-007 req0_data  input  16  port 0 payload.
REQ-008 req0_ready  output  1  port 0 word accepted this cycle.
REQ-009 req1_valid / req1_data / req1_ready  same widths and meaning for port 1.
REQ-010 mac_start  output  1  one-cycle start pulse to the frame transmitter.
REQ-011 mac_data  output  16  payload held to the transmitter.
REQ-012 mac_ethertype  output  16  ethertype held to the transmitter.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, START, HOLD.
REQ-015 IDLE: readyN SHALL be combinational, high only for the granted port, and only when that port's valid is high; transfer = valid & ready.
REQ-016 On transfer in IDLE: mac_data <= reqN_data, mac_ethertype <= ETHERTYPEN, last_grant <= N, state -> START.
REQ-017 START: mac_start SHALL be 1 for exactly this one cycle; counter <= FRAME_CYCLES-2; state -> HOLD.
REQ-018 HOLD: counter decrements each cycle; at counter==0 state -> IDLE; no ready asserted in START or HOLD.
REQ-019 Consecutive mac_start pulses SHALL be separated by at least FRAME_CYCLES+1 cycles (transfer cycle included); back-to-back valid gives exactly FRAME_CYCLES+1.
REQ-020 mac_data and mac_ethertype SHALL remain constant from the START cycle until the next transfer.
REQ-021 Single valid port: that port is granted regardless of last_grant.
REQ-022 Both valid (round-robin mode): grant the port not equal to last_grant.
REQ-023 valid dropped before grant: no transfer, no state change; valid held through START/HOLD is not consumed until next IDLE.
REQ-024 Counter width SHALL be $clog2(FRAME_CYCLES)+1 bits; no wrap-around permitted.

Reset
REQ-025 While rst_n==0 at a clk edge: state <= HOLD, counter <= FRAME_CYCLES-2, last_grant <= 1, mac_data <= 0, mac_ethertype <= 0.
REQ-026 Consequently after reset mac_start=0, req0_ready=req1_ready=0, busy=1, and first grant occurs no earlier than FRAME_CYCLES-1 cycles after rst_n rises, so an in-flight frame in the unreset transmitter completes.
REQ-027 Reset asserted mid-HOLD or in START SHALL abort the current schedule and take the REQ-025 values on the next edge; no second start pulse results.

Configuration
REQ-028 Macro ETHER_TX_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win when both valid; last_grant still updated but unused.
REQ-029 Macro undefined: round-robin per REQ-022.

Verification
REQ-030 Reset release, req0_valid=1 held with data 16'hBEEF -> req0_ready first high FRAME_CYCLES-1 cycles after rst_n rise; mac_start 1 cycle later; mac_data=16'hBEEF, mac_ethertype=16'h88B5.
REQ-031 Both valid continuously, data0=16'h0001, data1=16'h0002 -> grants alternate 0,1,0,1; mac_start spacing exactly 346 cycles (fixed-prio build: grants 0,0,0,0).
REQ-032 req1_valid pulsed during HOLD only -> no req1_ready, no extra mac_start, mac_data unchanged.
REQ-033 rst_n low for 1 cycle 100 cycles into HOLD -> busy stays 1, mac_start 0 until 344 cycles after rst_n rise, then normal grant.
REQ-034 Full frame through mac_tx: port 1 data 16'h1234 -> txen high for 288 dibits, ethertype field 16'h88B6, payload 16'h1234, FCS matching a software CRC32 model.
